// File: rtl/led_mem_pkg.sv
// led_mem_pkg: shared constants and types for the led_mem arbiter slice.
//   ADDR_W / DATA_W : geometry of the 16x16 led_mem block RAM
//   req_id_t        : requester identifier (0 = button sequencer, 1 = scan reader)
//   rd_tag_t        : in-flight read tag (valid + owner), one stage behind issue
package led_mem_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;

  typedef logic req_id_t;

  typedef struct packed {
    logic    vld;
    req_id_t own;
  } rd_tag_t;
endpackage

// File: rtl/led_mem_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin picker.
//   elig     : eligible requesters, bit N = requester N
//   last     : requester granted most recently (held by the parent)
//   grant    : one-hot winner, all zero when nobody is eligible
//   last_nxt : value of last after this decision (unchanged on no grant)
module rr_arb2
  import led_mem_pkg::*;
(
  input  logic [1:0] elig,
  input  req_id_t    last,
  output logic [1:0] grant,
  output req_id_t    last_nxt
);

  always_comb begin
    grant    = 2'b00;
    last_nxt = last;
    case (elig)
      2'b01: begin
        grant    = 2'b01;
        last_nxt = 1'b0;
      end
      2'b10: begin
        grant    = 2'b10;
        last_nxt = 1'b1;
      end
      2'b11: begin
        // Both want it: the one that did not go last wins.
        if (last == 1'b1) begin
          grant    = 2'b01;
          last_nxt = 1'b0;
        end else begin
          grant    = 2'b10;
          last_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/led_mem_arbiter.sv
// led_mem_arbiter: shares the single-port led_mem RAM between the button
// sequencer (requester 0) and the scan reader (requester 1).
//   clk_g, rst               : clock, synchronous active-high reset
//   reqN/weN/addrN/dinN      : requester N access, held until gntN
//   gntN                     : 1-cycle pulse, access issued to RAM this cycle
//   rvalidN/rdataN           : read return (rdataN holds after rvalidN drops)
//   mem_ena/wea/addra/dina   : registered RAM port-A controls
//   mem_douta                : RAM read data, one cycle after the read edge
// Decision at edge ending T, issue in T+1, read data returned in T+2.
module led_mem_arbiter
  import led_mem_pkg::*;
#(
  parameter int ADDR_W = led_mem_pkg::ADDR_W,
  parameter int DATA_W = led_mem_pkg::DATA_W
) (
  input  logic              clk_g,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] din0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] din1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_ena,
  output logic [0:0]        mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [DATA_W-1:0] mem_dina,
  input  logic [DATA_W-1:0] mem_douta
);

  logic [1:0]        elig;
  logic [1:0]        grant;
  req_id_t           last;
  req_id_t           last_nxt;
  rd_tag_t           tag;
  logic              ena_q;
  logic              wea_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  // A requester is masked in its grant cycle: its req is still up while it
  // reacts to gnt, and must not win a second time for the same access.
  assign elig = {req1 & ~gnt1, req0 & ~gnt0};

  rr_arb2 u_arb (
    .elig     (elig),
    .last     (last),
    .grant    (grant),
    .last_nxt (last_nxt)
  );

  always_ff @(posedge clk_g) begin
    if (rst) begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      ena_q     <= 1'b0;
      wea_q     <= 1'b0;
      mem_addra <= '0;
      mem_dina  <= '0;
      last      <= 1'b1;
      tag       <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      gnt0  <= grant[0];
      gnt1  <= grant[1];
      ena_q <= |grant;
      wea_q <= grant[1] ? we1 : (grant[0] ? we0 : 1'b0);
      // Address/data hold their last value while idle.
      if (|grant) begin
        mem_addra <= grant[1] ? addr1 : addr0;
        mem_dina  <= grant[1] ? din1  : din0;
      end
      last <= last_nxt;
      // last already names the owner of the access issued this cycle.
      tag.vld <= ena_q & ~wea_q;
      tag.own <= last;
      if (rvalid0) rdata0_q <= mem_douta;
      if (rvalid1) rdata1_q <= mem_douta;
    end
  end

  // rst gating cancels an access issued in the reset cycle and hides any
  // read return that would land in it.
  assign mem_ena    = ena_q & ~rst;
  assign mem_wea[0] = wea_q & ~rst;

  assign rvalid0 = tag.vld & (tag.own == 1'b0) & ~rst;
  assign rvalid1 = tag.vld & (tag.own == 1'b1) & ~rst;

  assign rdata0 = rvalid0 ? mem_douta : rdata0_q;
  assign rdata1 = rvalid1 ? mem_douta : rdata1_q;

endmodule
